ordered_merge_fsm: RTL

Parametrised N-channel successor to the two-stream output merge controller. Sits between NUM_CH field-encoder FIFOs (varint, raw data, and future encoders) and the single output FIFO. Pops one item at a time from whichever channel holds the next item in serialisation order, tracked by a running output index. Adds deterministic cross-channel priority, modulo index wrap, full-stall re-arbitration on live valids, and a sticky stall-timeout error.

---
 rtl/ordered_merge_pkg.sv | 38 +++
 rtl/merge_arbiter.sv | 63 ++++++
 rtl/ordered_merge_fsm.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ordered_merge_pkg.sv
// Shared types and helpers for the ordered output merge controller.
package ordered_merge_pkg;

   localparam int DEF_NUM_CH  = 4;
   localparam int DEF_IDX_W   = 10;
   localparam int DEF_TIMEOUT = 255;

   // Stall timer width; covers TIMEOUT up to 2^16-1.
   localparam int TMR_W = 16;

   // Upper bounds for the generic index slicer (8 channels x 32-bit index).
   localparam int MAX_IDX_W = 32;
   localparam int MAX_BUS_W = 256;

   // One-hot state encoding.
   typedef enum logic [4:0] {
      S_INIT  = 5'b00001,
      S_WAIT  = 5'b00010,
      S_PUSH  = 5'b00100,
      S_FULL  = 5'b01000,
      S_ERROR = 5'b10000
   } state_e;

   // Pull channel ch's order index (width bits) out of a zero-extended packed bus.
   function automatic logic [MAX_IDX_W-1:0] ch_slice(input logic [MAX_BUS_W-1:0] bus,
                                                     input int ch,
                                                     input int width);
      logic [MAX_IDX_W-1:0] r;
      logic [7:0]           pos;
      r = '0;
      for (int i = 0; i < MAX_IDX_W; i++) begin
         pos = 8'(ch * width + i);
         if (i < width) r[i] = bus[pos];
      end
      return r;
   endfunction

endpackage

// File: rtl/merge_arbiter.sv
// Combinational next-item arbiter: finds the channel whose head index is the
// current output index (EQ) or the one after it (NX), lowest channel first,
// with any EQ beating any NX.
import ordered_merge_pkg::*;

module merge_arbiter #(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int IDX_W  = DEF_IDX_W
) (
   input  logic [NUM_CH*IDX_W-1:0] ch_index_q,
   input  logic [NUM_CH-1:0]       ch_data_valid,
   input  logic [IDX_W-1:0]        out_index,
   output logic                    any_match,
   output logic [NUM_CH-1:0]       grant_onehot,
   output logic                    grant_inc
);

   logic [MAX_BUS_W-1:0] bus_ext;
   logic [IDX_W-1:0]     next_index;
   logic [IDX_W-1:0]     head;
   logic [NUM_CH-1:0]    eq;
   logic [NUM_CH-1:0]    nx;

   assign bus_ext    = MAX_BUS_W'(ch_index_q);
   // Natural IDX_W-bit wrap makes the last index match index 0 as NX.
   assign next_index = out_index + IDX_W'(1);

   // Per-channel EQ / NX match vectors.
   always_comb begin
      head = '0;
      eq   = '0;
      nx   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         head  = IDX_W'(ch_slice(bus_ext, c, IDX_W));
         eq[c] = ch_data_valid[c] && (head == out_index);
         nx[c] = ch_data_valid[c] && (head == next_index);
      end
   end

   // Priority select: EQ class first, lowest channel wins within a class.
   always_comb begin
      any_match    = (|eq) || (|nx);
      grant_onehot = '0;
      grant_inc    = 1'b0;
      if (|eq) begin
         for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (eq[c]) begin
               grant_onehot    = '0;
               grant_onehot[c] = 1'b1;
            end
         end
      end else if (|nx) begin
         grant_inc = 1'b1;
         for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (nx[c]) begin
               grant_onehot    = '0;
               grant_onehot[c] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ordered_merge_fsm.sv
// Ordered N-channel output merge controller.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_INIT  | clear output FIFO, index, stall timer and grant
// S_WAIT  | arbitrate on channel heads; time non-matching valids
// S_PUSH  | one-cycle pop of granted channel and push to output FIFO
// S_FULL  | match seen while output full; re-arbitrate on release
// S_ERROR | stall timeout; sticky until reset
import ordered_merge_pkg::*;

module ordered_merge_fsm #(
   parameter int NUM_CH  = DEF_NUM_CH,
   parameter int IDX_W   = DEF_IDX_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    out_fifo_full,
   output logic                    out_fifo_clr,
   output logic                    out_fifo_push,
   output logic [NUM_CH-1:0]       ch_enable,
   input  logic [NUM_CH*IDX_W-1:0] ch_index_q,
   input  logic [NUM_CH-1:0]       ch_data_valid,
   output logic [NUM_CH-1:0]       ch_data_accepted,
   output logic [IDX_W-1:0]        out_index,
   output logic                    stall_error
);

   // Down-counter reload value; terminal count is 1.
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   out_index_q, out_index_d;
   logic [TMR_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [NUM_CH-1:0]  sel_q, sel_d;
   logic               inc_q, inc_d;

   logic               any_match;
   logic [NUM_CH-1:0]  grant_onehot;
   logic               grant_inc;

   merge_arbiter #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_arb (
      .ch_index_q    (ch_index_q),
      .ch_data_valid (ch_data_valid),
      .out_index     (out_index_q),
      .any_match     (any_match),
      .grant_onehot  (grant_onehot),
      .grant_inc     (grant_inc)
   );

   // Next-state, index, stall timer and grant computation.
   always_comb begin
      state_d     = state_q;
      out_index_d = out_index_q;
      stall_cnt_d = stall_cnt_q;
      sel_d       = sel_q;
      inc_d       = inc_q;
      case (state_q)
         S_INIT: begin
            out_index_d = '0;
            stall_cnt_d = TMR_LOAD;
            sel_d       = '0;
            inc_d       = 1'b0;
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            if (any_match) begin
               stall_cnt_d = TMR_LOAD;
               if (!out_fifo_full) begin
                  sel_d   = grant_onehot;
                  inc_d   = grant_inc;
                  state_d = S_PUSH;
               end else begin
                  state_d = S_FULL;
               end
            end else if (|ch_data_valid) begin
               if (stall_cnt_q == TMR_W'(1)) state_d = S_ERROR;
               else stall_cnt_d = stall_cnt_q - TMR_W'(1);
            end else begin
               stall_cnt_d = TMR_LOAD;
            end
         end
         S_PUSH: begin
            if (inc_q) out_index_d = out_index_q + IDX_W'(1);
            state_d = S_WAIT;
         end
         S_FULL: begin
            // A channel may have withdrawn while we waited; fall back to WAIT then.
            if (!out_fifo_full) begin
               if (any_match) begin
                  sel_d   = grant_onehot;
                  inc_d   = grant_inc;
                  state_d = S_PUSH;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_INIT;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_INIT;
         out_index_q <= '0;
         stall_cnt_q <= TMR_LOAD;
         sel_q       <= '0;
         inc_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_index_q <= out_index_d;
         stall_cnt_q <= stall_cnt_d;
         sel_q       <= sel_d;
         inc_q       <= inc_d;
      end
   end

   // Output decode straight from registered state; strobes only in INIT/PUSH.
   always_comb begin
      out_fifo_clr     = (state_q == S_INIT);
      out_fifo_push    = (state_q == S_PUSH);
      ch_enable        = (state_q == S_PUSH) ? sel_q : '0;
      ch_data_accepted = (state_q == S_PUSH) ? sel_q : '0;
      stall_error      = (state_q == S_ERROR);
      out_index        = out_index_q;
   end

endmodule
